// File: rtl/sam_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, default
// bus widths and the default transaction timeout.
package sam_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 255;

    // Width of the per-transaction timeout counter.
    localparam int TMO_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_MEM = 2'd2,
        DONE     = 2'd3
    } state_e;

endpackage : sam_pkg

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-input round-robin winner selection. A lone requester always wins; on a
// tie the requester that was not served last wins. The pointer remembers who
// was served last and comes out of reset as "last served = 1", so requester 0
// wins the first tie.
module rr_pick2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic       valid,
    output logic       winner
);

    logic last_q;
    logic last_d;

    // Winner decode and pointer next-value.
    always_comb begin
        // NOTE: every signal driven here gets a value before any branch, so
        // no path can leave it unassigned and infer a latch.
        valid  = |req;
        winner = (req == 2'b11) ? ~last_q : req[1];
        last_d = update ? served : last_q;
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule : rr_pick2

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter. Requester 0 is the CPU, requester 1 the
// DMA/IO port. One transaction at a time: the winner's command is latched in
// IDLE, strobed to memory in ISSUE, completed in WAIT_MEM when the memory
// lowers mem_wait, and signalled with a one-cycle done pulse in DONE. A
// transaction that outlives TIMEOUT cycles is aborted with err.
module mem_arbiter
    import sam_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_rw,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_rw,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic              m0_done,
    output logic              m1_done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wait,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT);

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [1:0]            grant_q, grant_d;
    logic                  rw_q, rw_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [TMO_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic                  pick_valid;
    logic                  pick_winner;
    logic                  rr_update;
    logic [TMO_CNT_W-1:0]  cnt_inc;
    logic                  timeout_hit;

    rr_pick2 u_rr_pick2 (
        .clk    (clk),
        .rst    (rst),
        .req    ({m1_req, m0_req}),
        .update (rr_update),
        .served (owner_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    assign cnt_inc     = cnt_q + 1'b1;
    assign timeout_hit = (cnt_inc == TMO_LIMIT);

    // Next-state, command latch, timeout counting and read-data capture.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rr_update = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_winner;
                    grant_d = pick_winner ? 2'b10 : 2'b01;
                    rw_d    = pick_winner ? m1_rw    : m0_rw;
                    addr_d  = pick_winner ? m1_addr  : m0_addr;
                    wdata_d = pick_winner ? m1_wdata : m0_wdata;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_inc;
                if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (mem_wait) begin
                    state_d = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                cnt_d = cnt_inc;
                // Completion is checked first so it wins a same-cycle timeout.
                if (!mem_wait) begin
                    if (rw_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                grant_d   = 2'b00;
                rr_update = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            grant_q <= 2'b00;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign m0_grant  = grant_q[0];
    assign m1_grant  = grant_q[1];
    assign m0_done   = (state_q == DONE) && !owner_q;
    assign m1_done   = (state_q == DONE) &&  owner_q;
    assign err       = (state_q == DONE) &&  err_q;
    assign rdata     = rdata_q;
    assign mem_req   = (state_q == ISSUE);
    assign mem_rw    = rw_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A behavioural memory answers each
// request after a programmable acknowledge delay and busy time; a transaction
// level model predicts winner, latency, err and rdata for every transaction.
module tb_mem_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int TMO = 255;

    logic          clk;
    logic          rst;
    logic          m0_req, m1_req;
    logic          m0_rw, m1_rw;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_grant, m1_grant;
    logic          m0_done, m1_done;
    logic          err;
    logic [DW-1:0] rdata;
    logic          mem_req;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wait;
    logic [DW-1:0] mem_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_rw     (m0_rw),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m1_req    (m1_req),
        .m1_rw     (m1_rw),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m0_grant  (m0_grant),
        .m1_grant  (m1_grant),
        .m0_done   (m0_done),
        .m1_done   (m1_done),
        .err       (err),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wait  (mem_wait),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Transaction-level reference state.
    int            last_served = 1;
    logic [DW-1:0] rdata_model = '0;
    int            last_done_cyc = 0;

    // Behavioural memory contents and response timing.
    logic [DW-1:0] mem_model [256];
    int            rsp_ack  = 0;
    int            rsp_hold = 1;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responder: acknowledges by raising mem_wait rsp_ack cycles after
    // seeing mem_req, stays busy rsp_hold cycles, then lowers mem_wait with
    // read data. Gives up if the arbiter resets or aborts the transaction.
    initial begin
        logic [7:0]    a;
        logic          r;
        logic [DW-1:0] w;
        bit            aborted;
        mem_wait  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst && mem_req && !mem_wait) begin
                a = mem_addr[7:0];
                r = mem_rw;
                w = mem_wdata;
                aborted = 1'b0;
                for (int i = 0; i < rsp_ack; i++) begin
                    @(negedge clk);
                    if (rst || m0_done || m1_done) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    mem_wait = 1'b1;
                    for (int i = 0; i < rsp_hold; i++) begin
                        @(negedge clk);
                        if (rst || m0_done || m1_done) begin
                            aborted = 1'b1;
                            break;
                        end
                    end
                end
                if (!aborted) begin
                    if (r) mem_rdata = mem_model[a];
                    else   mem_model[a] = w;
                end
                mem_wait = 1'b0;
            end
        end
    end

    // Round-robin rule: a lone requester wins, a tie goes to the one not
    // served last.
    function automatic int pick(input bit r0, input bit r1, input int last);
        if (r0 && r1) return 1 - last;
        if (r0)       return 0;
        return 1;
    endfunction

    // One complete transaction: present requests in IDLE, then check grant,
    // the ISSUE command, done/err timing, rdata and the return to IDLE.
    task automatic run_txn(input bit r0, input bit r1,
                           input bit rw0, input bit rw1,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                           input int ack, input int hold, input bit drop);
        int            win, k, exp_n, n, req_cycles;
        bit            got, both, exp_err;
        logic          exp_rw;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata, exp_rdata;
        logic [1:0]    exp_vec;

        rsp_ack  = ack;
        rsp_hold = hold;
        m0_req = r0;  m0_rw = rw0;  m0_addr = a0;  m0_wdata = w0;
        m1_req = r1;  m1_rw = rw1;  m1_addr = a1;  m1_wdata = w1;

        win       = pick(r0, r1, last_served);
        exp_vec   = (win == 1) ? 2'b10 : 2'b01;
        exp_rw    = (win == 1) ? rw1 : rw0;
        exp_addr  = (win == 1) ? a1  : a0;
        exp_wdata = (win == 1) ? w1  : w0;
        k         = ack + 1 + hold;
        exp_n     = (k <= TMO) ? k : TMO;
        exp_err   = (k > TMO);

        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m0_grant || m1_grant) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL grant_wait: no grant within 8 cycles");
            m0_req = 1'b0;
            m1_req = 1'b0;
            return;
        end

        n_checks++;
        if ({m1_grant, m0_grant} !== exp_vec) begin
            n_errors++;
            $display("FAIL grant_winner: got %b expected %b", {m1_grant, m0_grant}, exp_vec);
        end
        n_checks++;
        if ({mem_req, mem_rw, mem_addr, mem_wdata} !== {1'b1, exp_rw, exp_addr, exp_wdata}) begin
            n_errors++;
            $display("FAIL issue_cmd: got req=%b rw=%b addr=%h wdata=%h expected req=1 rw=%b addr=%h wdata=%h",
                     mem_req, mem_rw, mem_addr, mem_wdata, exp_rw, exp_addr, exp_wdata);
        end

        if (drop) begin
            m0_req = 1'b0;
            m1_req = 1'b0;
        end

        both       = 1'b0;
        req_cycles = 1;
        got        = 1'b0;
        n          = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            n = i;
            if (m0_grant && m1_grant) both = 1'b1;
            if (mem_req) req_cycles++;
            if (m0_done || m1_done) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL done_wait: no done within 400 cycles");
            m0_req = 1'b0;
            m1_req = 1'b0;
            return;
        end

        exp_rdata = (!exp_err && exp_rw) ? mem_model[exp_addr[7:0]] : rdata_model;

        n_checks++;
        if ({m1_done, m0_done} !== exp_vec || n != exp_n) begin
            n_errors++;
            $display("FAIL done_pulse: got %b after %0d cycles expected %b after %0d cycles",
                     {m1_done, m0_done}, n, exp_vec, exp_n);
        end
        n_checks++;
        if (err !== exp_err) begin
            n_errors++;
            $display("FAIL err_flag: got %b expected %b", err, exp_err);
        end
        n_checks++;
        if (rdata !== exp_rdata) begin
            n_errors++;
            $display("FAIL rdata: got %h expected %h", rdata, exp_rdata);
        end
        n_checks++;
        if (req_cycles != ack + 1 || both || mem_addr !== exp_addr) begin
            n_errors++;
            $display("FAIL bus_hold: got req_cycles=%0d both=%b addr=%h expected %0d 0 %h",
                     req_cycles, both, mem_addr, ack + 1, exp_addr);
        end

        rdata_model   = exp_rdata;
        last_served   = win;
        last_done_cyc = cyc;
        m0_req = 1'b0;
        m1_req = 1'b0;

        @(negedge clk);
        n_checks++;
        if ({m1_grant, m0_grant, m1_done, m0_done, err, mem_req} !== 6'b0) begin
            n_errors++;
            $display("FAIL back_to_idle: got grant=%b done=%b err=%b mem_req=%b expected all 0",
                     {m1_grant, m0_grant}, {m1_done, m0_done}, err, mem_req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_req = 1'b1;
        m1_req = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({m1_grant, m0_grant, m1_done, m0_done, err, mem_req} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got grant=%b done=%b err=%b mem_req=%b expected all 0",
                     {m1_grant, m0_grant}, {m1_done, m0_done}, err, mem_req);
        end
        n_checks++;
        if ({rdata, mem_rw, mem_addr, mem_wdata} !== {16'h0000, 1'b1, 16'h0000, 16'h0000}) begin
            n_errors++;
            $display("FAIL reset_data: got rdata=%h rw=%b addr=%h wdata=%h expected 0 1 0 0",
                     rdata, mem_rw, mem_addr, mem_wdata);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        rst = 1'b0;
        last_served = 1;
        rdata_model = '0;
        @(negedge clk);
    endtask

    task automatic test_read();
        mem_model[8'h10] = 16'hBEEF;
        run_txn(1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 3, 1'b0);
    endtask

    task automatic test_write();
        run_txn(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h00FE, 16'h0000, 16'h1234, 0, 2, 1'b0);
    endtask

    task automatic test_tie();
        int prev;
        for (int t = 0; t < 4; t++) begin
            prev = last_done_cyc;
            run_txn(1'b1, 1'b1, 1'b1, 1'b0, 16'h0A00 + 16'(t), 16'h0B00 + 16'(t),
                    16'h1100 + 16'(t), 16'h2200 + 16'(t), 0, 1, 1'b0);
            if (t > 0) begin
                n_checks++;
                if (last_done_cyc - prev != 4) begin
                    n_errors++;
                    $display("FAIL b2b_period: got %0d cycles expected 4", last_done_cyc - prev);
                end
            end
        end
    endtask

    task automatic test_drop();
        run_txn(1'b1, 1'b0, 1'b1, 1'b1, 16'h0033, 16'h0000, 16'h0000, 16'h0000, 1, 2, 1'b1);
    endtask

    task automatic test_random();
        logic [1:0] r;
        for (int t = 0; t < 30; t++) begin
            r = 2'($urandom_range(1, 3));
            run_txn(r[0], r[1], 1'($urandom), 1'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    $urandom_range(0, 3), $urandom_range(1, 5), 1'b0);
        end
    endtask

    task automatic test_timeout();
        // Completion lands exactly on the timeout edge: completion wins.
        run_txn(1'b1, 1'b0, 1'b1, 1'b1, 16'h0044, 16'h0000, 16'h0000, 16'h0000, 0, TMO - 1, 1'b0);
        // One cycle later than the limit: aborted with err.
        run_txn(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0055, 16'h0000, 16'h0000, 0, TMO, 1'b0);
        // Memory never finishes.
        run_txn(1'b1, 1'b0, 1'b1, 1'b1, 16'h0066, 16'h0000, 16'h0000, 16'h0000, 2, 390, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit got;
        bit seen_done;
        rsp_ack  = 0;
        rsp_hold = 30;
        m0_req = 1'b1;  m0_rw = 1'b1;  m0_addr = 16'h0077;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m0_grant && !mem_req && !m0_done) begin
                got = 1'b1;
                break;
            end
        end
        m0_req = 1'b0;
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL reach_wait_mem: transaction never reached WAIT_MEM");
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({m1_grant, m0_grant, m1_done, m0_done, err, mem_req, mem_rw, rdata} !==
            {6'b0, 1'b1, 16'h0000}) begin
            n_errors++;
            $display("FAIL reset_mid: got grant=%b done=%b err=%b mem_req=%b rw=%b rdata=%h expected 0 0 0 0 1 0",
                     {m1_grant, m0_grant}, {m1_done, m0_done}, err, mem_req, mem_rw, rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        last_served = 1;
        rdata_model = '0;
        seen_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (m0_done || m1_done || m0_grant || m1_grant) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done) begin
            n_errors++;
            $display("FAIL abandoned_txn: got activity after reset expected none");
        end
        run_txn(1'b1, 1'b1, 1'b0, 1'b0, 16'h0C00, 16'h0D00, 16'h3333, 16'h4444, 0, 1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = 16'($urandom);
        rst = 1'b1;
        m0_req = 1'b0;  m0_rw = 1'b1;  m0_addr = '0;  m0_wdata = '0;
        m1_req = 1'b0;  m1_rw = 1'b1;  m1_addr = '0;  m1_wdata = '0;

        test_reset();
        test_read();
        test_write();
        test_reset();
        test_tie();
        test_drop();
        test_random();
        test_timeout();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_mem_arbiter
